// File: rtl/block_serializer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : block_serializer_pkg
//  Description : Shared constants and state encoding for the block
//                serializer (2560-bit block = 40 words x 64 bits).
//  Revision    : 1.0 - initial release
// ============================================================================
package block_serializer_pkg;

    // One output word carries 8 pixels of 8 bits.
    localparam int WIDTH = 64;
    // One block is 8 rows x 5 sub-pel positions.
    localparam int WORDS = 40;
    // Word index width; 2**IDXW must cover WORDS.
    localparam int IDXW  = 6;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/block_serializer_word_select.sv
`default_nettype none
// ============================================================================
//  Module      : word_select
//  Description : Combinational WORDS:1 word mux. Index 0 selects the top
//                (oldest) slice of the packed block, so words come out in
//                the order they were packed.
//  Revision    : 1.0 - initial release
// ============================================================================
module word_select #(
    parameter int WIDTH = 64,
    parameter int WORDS = 40,
    parameter int IDXW  = 6
) (
    input  logic [WIDTH*WORDS-1:0] data,
    input  logic [IDXW-1:0]        idx,
    output logic [WIDTH-1:0]       word
);

    logic [WIDTH-1:0] w_words [WORDS];

    // Unpack in reversed order: entry i is slice [WIDTH*(WORDS-i)-1 -: WIDTH].
    for (genvar i = 0; i < WORDS; i++) begin : g_words
        assign w_words[i] = data[WIDTH*(WORDS-i)-1 -: WIDTH];
    end

    // Out-of-range indices read as zero rather than an undefined entry.
    always_comb begin
        word = '0;
        if ({1'b0, idx} < (IDXW+1)'(WORDS)) begin
            word = w_words[idx];
        end
    end

endmodule
`default_nettype wire

// File: rtl/register.sv
`default_nettype none
// ============================================================================
//  Module      : register
//  Description : Parameterised load-enabled register with asynchronous
//                active-low clear and active-low load strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module register #(
    parameter int W = 1
) (
    input  logic         clock,
    input  logic         reset_L,
    input  logic         load_L,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] r_q;

    // Capture d whenever load_L is low; clear immediately on reset.
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            r_q <= '0;
        end else if (!load_L) begin
            r_q <= d;
        end
    end

    assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/block_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : block_serializer
//  Description : Captures one 40 x 64-bit block in a single handshake and
//                drains it word by word, oldest word first. A new block can
//                be taken on the last-word handshake so blocks stream with
//                no bubble.
//  Revision    : 1.0 - initial release
// ============================================================================
module block_serializer
    import block_serializer_pkg::*;
(
    input  logic                   clock,
    input  logic                   reset_L,
    input  logic                   blk_valid,
    input  logic [WIDTH*WORDS-1:0] blk_data,
    output logic                   blk_ready,
    output logic                   out_valid,
    output logic [WIDTH-1:0]       out_data,
    output logic [IDXW-1:0]        out_idx,
    output logic                   out_last,
    input  logic                   out_ready,
    output logic                   busy
);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [IDXW-1:0]        r_idx;
    logic [IDXW-1:0]        w_idx_nxt;
    logic [WIDTH*WORDS-1:0] w_buffer;
    logic [WIDTH-1:0]       w_word;
    logic                   w_send;
    logic                   w_last;
    logic                   w_load;

    assign w_send = (r_state == SEND);
    assign w_last = w_send && (r_idx == IDXW'(WORDS - 1));

    // In SEND a new block may only enter on the final word's handshake;
    // this makes blk_ready combinational on out_ready.
    assign blk_ready = w_send ? (w_last && out_ready) : 1'b1;
    assign w_load    = blk_valid && blk_ready;

    register #(
        .W (WIDTH*WORDS)
    ) u_buffer (
        .clock   (clock),
        .reset_L (reset_L),
        .load_L  (!w_load),
        .d       (blk_data),
        .q       (w_buffer)
    );

    word_select #(
        .WIDTH (WIDTH),
        .WORDS (WORDS),
        .IDXW  (IDXW)
    ) u_word_select (
        .data (w_buffer),
        .idx  (r_idx),
        .word (w_word)
    );

    // Outputs come only from registered buffer/index/state; gated to zero
    // when idle so nothing stale is visible.
    assign out_valid = w_send;
    assign busy      = w_send;
    assign out_last  = w_last;
    assign out_idx   = w_send ? r_idx  : '0;
    assign out_data  = w_send ? w_word : '0;

    // State and word-index registers.
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            r_state <= IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // Next-state: advance on each accepted word, restart on a capture.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        case (r_state)
            IDLE: begin
                if (w_load) begin
                    w_state_nxt = SEND;
                    w_idx_nxt   = '0;
                end
            end
            SEND: begin
                if (out_ready) begin
                    if (!w_last) begin
                        w_idx_nxt = r_idx + IDXW'(1);
                    end else if (w_load) begin
                        w_idx_nxt = '0;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_idx_nxt   = '0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_block_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_block_serializer
//  Description : Directed self-checking bench for block_serializer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_block_serializer;

    logic          clock = 1'b0;
    logic          reset_L;
    logic          blk_valid;
    logic [2559:0] blk_data;
    logic          blk_ready;
    logic          out_valid;
    logic [63:0]   out_data;
    logic [5:0]    out_idx;
    logic          out_last;
    logic          out_ready;
    logic          busy;

    int n_assert = 0;
    int n_fail   = 0;
    int pulses   = 0;

    always #5 clock = ~clock;

    block_serializer dut (
        .clock     (clock),
        .reset_L   (reset_L),
        .blk_valid (blk_valid),
        .blk_data  (blk_data),
        .blk_ready (blk_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .out_ready (out_ready),
        .busy      (busy)
    );

    // Block whose word k (top-down) is base+k.
    function automatic logic [2559:0] mk_block(input logic [63:0] base);
        logic [2559:0] b;
        b = '0;
        for (int k = 0; k < 40; k++) begin
            b[64*(40-k)-1 -: 64] = base + 64'(k);
        end
        return b;
    endfunction

    task automatic ck(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic ck_word(input string tag, input logic [63:0] base, input int k);
        ck({tag, "_valid"}, 64'(out_valid), 64'd1);
        ck({tag, "_busy"},  64'(busy),      64'd1);
        ck({tag, "_data"},  out_data,       base + 64'(k));
        ck({tag, "_idx"},   64'(out_idx),   64'(k));
        ck({tag, "_last"},  64'(out_last),  64'(k == 39));
    endtask

    task automatic ck_idle(input string tag);
        ck({tag, "_valid"}, 64'(out_valid), 64'd0);
        ck({tag, "_busy"},  64'(busy),      64'd0);
        ck({tag, "_ready"}, 64'(blk_ready), 64'd1);
        ck({tag, "_data"},  out_data,       64'd0);
        ck({tag, "_last"},  64'(out_last),  64'd0);
    endtask

    // Advance to just after the next rising edge.
    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_L   = 1'b0;
        blk_valid = 1'b0;
        out_ready = 1'b0;
        blk_data  = '0;

        // Reset then idle.
        repeat (3) @(posedge clock);
        #1;
        ck_idle("rst");
        ck("rst_idx", 64'(out_idx), 64'd0);
        reset_L = 1'b1;
        tick;
        tick;
        #1;
        ck_idle("rel");

        // Single block at full rate.
        blk_valid = 1'b1;
        blk_data  = mk_block(64'h0);
        out_ready = 1'b1;
        #1;
        ck("t2_ready_idle", 64'(blk_ready), 64'd1);
        for (int k = 0; k < 40; k++) begin
            tick;
            blk_valid = 1'b0;
            #1;
            ck_word("t2", 64'h0, k);
            ck("t2_blk_ready", 64'(blk_ready), 64'(k == 39));
        end
        tick;
        #1;
        ck_idle("t2_end");

        // Backpressure: ready low on every other cycle, 80 cycles total.
        blk_valid = 1'b1;
        blk_data  = mk_block(64'h0);
        out_ready = 1'b0;
        for (int c = 0; c < 80; c++) begin
            tick;
            blk_valid = 1'b0;
            out_ready = (c % 2 == 1);
            #1;
            ck_word("t3", 64'h0, c / 2);
        end
        tick;
        #1;
        ck_idle("t3_end");

        // Back-to-back blocks A then B with no gap.
        blk_valid = 1'b1;
        blk_data  = mk_block(64'hA000);
        out_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            tick;
            blk_valid = 1'b0;
            if (k == 39) begin
                blk_valid = 1'b1;
                blk_data  = mk_block(64'hB000);
            end
            #1;
            ck_word("t4a", 64'hA000, k);
            if (blk_ready) pulses++;
        end
        for (int k = 0; k < 40; k++) begin
            tick;
            blk_valid = 1'b0;
            #1;
            ck_word("t4b", 64'hB000, k);
            if (blk_ready && k < 39) pulses++;
        end
        ck("t4_ready_pulses", 64'(pulses), 64'd1);
        tick;
        #1;
        ck_idle("t4_end");

        // Asynchronous reset mid-drain after word 17.
        blk_valid = 1'b1;
        blk_data  = mk_block(64'h5000);
        out_ready = 1'b1;
        for (int k = 0; k < 18; k++) begin
            tick;
            blk_valid = 1'b0;
            #1;
            ck_word("t5", 64'h5000, k);
        end
        tick;
        reset_L = 1'b0;
        #1;
        ck_idle("t5_rst");
        ck("t5_rst_idx", 64'(out_idx), 64'd0);
        tick;
        tick;
        reset_L   = 1'b1;
        blk_valid = 1'b1;
        blk_data  = mk_block(64'hC000);
        #1;
        ck("t5_rel_ready", 64'(blk_ready), 64'd1);
        ck("t5_rel_valid", 64'(out_valid), 64'd0);
        for (int k = 0; k < 40; k++) begin
            tick;
            blk_valid = 1'b0;
            #1;
            ck_word("t5c", 64'hC000, k);
        end
        tick;
        #1;
        ck_idle("t5_end");

        // blk_data churn with blk_valid high while stalled is ignored.
        blk_valid = 1'b1;
        blk_data  = mk_block(64'hD000);
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        blk_data  = mk_block(64'hE000);
        #1;
        ck_word("t6_hold", 64'hD000, 0);
        ck("t6_blk_ready", 64'(blk_ready), 64'd0);
        for (int i = 0; i < 4; i++) begin
            tick;
            blk_data = (i % 2 == 0) ? mk_block(64'hF000) : mk_block(64'hE000);
            #1;
            ck_word("t6_stall", 64'hD000, 0);
            ck("t6_stall_ready", 64'(blk_ready), 64'd0);
        end
        blk_valid = 1'b0;
        out_ready = 1'b1;
        for (int k = 1; k < 40; k++) begin
            tick;
            #1;
            ck_word("t6_drain", 64'hD000, k);
        end
        tick;
        #1;
        ck_idle("t6_end");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
